idu_scoreboard_issue: RTL and testbench

- Parametrised successor to the single-stage decode/issue register. Adds per-register pending-write tracking, multiple writeback ports, and a valid/ready issue handshake.
- Sits between decode and EXU, next to an external async-read register file.
- Allows multiple in-flight writes per register (pipelined mul/div/LSU) and resolves RAW/WAW hazards without unit-specific busy signals.

---
 rtl/idu_scoreboard_issue.sv | 198 +++++++++++++++++++
 tb/tb_idu_scoreboard_issue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_scoreboard_issue.sv
// ---------------------------------------------------------------------------
// idu_scoreboard_issue
//
// Decode-to-EXU issue register with a per-register pending-write scoreboard.
// Each architectural register carries a small counter of writes that have
// issued but not yet written back. Several writes to one register may be in
// flight at once. A source operand is only accepted once every older write
// to it has completed. A destination is accepted only while its counter is
// below MAX_PEND. A writeback landing in the accepting cycle is forwarded
// straight into the operand register.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           decode -> issue handshake
//   in_rs1_en/addr, in_rs2_en/addr source operands (addresses also drive RF)
//   in_rd_en / in_rd_addr         destination register
//   rf_rs1_data / rf_rs2_data     async register file read data
//   wb_valid/wb_addr/wb_data      NUM_WB packed writeback ports, port 0 in LSBs
//   out_valid / out_ready         issue -> EXU handshake
//   out_rs1_data / out_rs2_data   registered operands
//   out_rd_en / out_rd_addr       registered destination
//   flush                         discard the held instruction
//   pend_err                      sticky: writeback seen with no pending write
// ---------------------------------------------------------------------------
module idu_scoreboard_issue #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 11,
    parameter int REG_ADDR_W = 4,
    parameter int NUM_WB     = 2,
    parameter int MAX_PEND   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_rs1_en,
    input  logic                         in_rs2_en,
    input  logic [REG_ADDR_W-1:0]        in_rs1_addr,
    input  logic [REG_ADDR_W-1:0]        in_rs2_addr,
    input  logic                         in_rd_en,
    input  logic [REG_ADDR_W-1:0]        in_rd_addr,
    input  logic [XLEN-1:0]              rf_rs1_data,
    input  logic [XLEN-1:0]              rf_rs2_data,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*REG_ADDR_W-1:0] wb_addr,
    input  logic [NUM_WB*XLEN-1:0]       wb_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_rs1_data,
    output logic [XLEN-1:0]              out_rs2_data,
    output logic                         out_rd_en,
    output logic [REG_ADDR_W-1:0]        out_rd_addr,
    input  logic                         flush,
    output logic                         pend_err
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam int DEC_W = $clog2(NUM_WB + 1);

    logic [CNT_W-1:0]      pend     [NUM_REGS];
    logic [CNT_W-1:0]      pend_nxt [NUM_REGS];
    logic [DEC_W-1:0]      dec_cnt  [NUM_REGS];
    logic [NUM_REGS-1:0]   underflow;

    logic                  issue_fire;
    logic                  accept;

    logic [1:0]            src_en;
    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [XLEN-1:0]       src_rf   [2];
    logic [XLEN-1:0]       src_data [2];
    logic [1:0]            src_haz;
    logic                  rd_haz;
    logic                  held_rd_match;

    assign issue_fire = out_valid & out_ready & ~flush;

    assign src_en      = {in_rs2_en, in_rs1_en};
    assign src_addr[0] = in_rs1_addr;
    assign src_addr[1] = in_rs2_addr;
    assign src_rf[0]   = rf_rs1_data;
    assign src_rf[1]   = rf_rs2_data;

    // Per-register count of writebacks arriving this cycle. Addresses at or
    // above NUM_REGS never match any r and are therefore ignored.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            // NOTE: every combinational output gets a default before any
            // conditional assignment, so no path leaves it unassigned (no latch).
            dec_cnt[r] = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] &&
                    int'(wb_addr[p*REG_ADDR_W +: REG_ADDR_W]) == r) begin
                    dec_cnt[r] = dec_cnt[r] + DEC_W'(1);
                end
            end
        end
    end

    // Net counter update: issue increment and writeback decrements combine.
    // A decrement below zero clamps at zero and flags pend_err.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            int sum;
            sum = int'(pend[r]) +
                  ((issue_fire && out_rd_en && int'(out_rd_addr) == r) ? 1 : 0);
            underflow[r] = 1'b0;
            pend_nxt[r]  = '0;
            if (int'(dec_cnt[r]) > sum) begin
                underflow[r] = 1'b1;
            end else begin
                pend_nxt[r] = CNT_W'(sum - int'(dec_cnt[r]));
            end
        end
    end

    // Source hazards and writeback forwarding. When several ports write the
    // same source register, the highest-indexed port wins.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_haz[s]  = 1'b0;
            src_data[s] = src_rf[s];
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && wb_addr[p*REG_ADDR_W +: REG_ADDR_W] == src_addr[s]) begin
                    src_data[s] = wb_data[p*XLEN +: XLEN];
                end
            end
            if (src_en[s] && int'(src_addr[s]) < NUM_REGS) begin
                // The held producer has not been counted in pend yet.
                if (out_valid && out_rd_en && out_rd_addr == src_addr[s]) begin
                    src_haz[s] = 1'b1;
                end
                // Pending writes not fully retired by this cycle's writebacks.
                if (int'(pend[src_addr[s]]) > int'(dec_cnt[src_addr[s]])) begin
                    src_haz[s] = 1'b1;
                end
            end
        end
    end

    // Destination limit: same-cycle writebacks are deliberately not credited,
    // which keeps this path off the writeback compare logic.
    always_comb begin
        held_rd_match = out_valid && out_rd_en && out_rd_addr == in_rd_addr;
        rd_haz        = 1'b0;
        if (in_rd_en && int'(in_rd_addr) < NUM_REGS) begin
            if (int'(pend[in_rd_addr]) + (held_rd_match ? 1 : 0) >= MAX_PEND) begin
                rd_haz = 1'b1;
            end
        end
    end

    assign in_ready = ~(|src_haz) & ~rd_haz & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // NOTE: the counter array is architectural state rather than bulk storage,
    // so every entry is reset; a stale count would stall issue forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= '0;
            end
            pend_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= pend_nxt[r];
            end
            if (|underflow) begin
                pend_err <= 1'b1;
            end
        end
    end

    // Issue register. Flush wins; accept reloads even while the current
    // instruction fires, giving full throughput.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_rd_en    <= 1'b0;
            out_rd_addr  <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_rd_en    <= in_rd_en;
            out_rd_addr  <= in_rd_addr;
            out_rs1_data <= src_data[0];
            out_rs2_data <= src_data[1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idu_scoreboard_issue.sv
// ---------------------------------------------------------------------------
// tb_idu_scoreboard_issue
//
// Directed bench for idu_scoreboard_issue with default parameters
// (NUM_REGS=11, NUM_WB=2, MAX_PEND=3). Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns after that or 1 ns after the next edge.
// Scoreboard counters are observed through the instance hierarchy.
// ---------------------------------------------------------------------------
module tb_idu_scoreboard_issue;

    localparam int XLEN = 32;
    localparam int AW   = 4;
    localparam int NWB  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_rs1_en, in_rs2_en;
    logic [AW-1:0]   in_rs1_addr, in_rs2_addr;
    logic            in_rd_en;
    logic [AW-1:0]   in_rd_addr;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic [NWB-1:0]  wb_valid;
    logic [NWB*AW-1:0]   wb_addr;
    logic [NWB*XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rs1_data, out_rs2_data;
    logic            out_rd_en;
    logic [AW-1:0]   out_rd_addr;
    logic            flush;
    logic            pend_err;

    int errors = 0;
    int checks = 0;

    idu_scoreboard_issue dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1_en    (in_rs1_en),
        .in_rs2_en    (in_rs2_en),
        .in_rs1_addr  (in_rs1_addr),
        .in_rs2_addr  (in_rs2_addr),
        .in_rd_en     (in_rd_en),
        .in_rd_addr   (in_rd_addr),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd_en    (out_rd_en),
        .out_rd_addr  (out_rd_addr),
        .flush        (flush),
        .pend_err     (pend_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        in_valid    = 1'b0;
        in_rs1_en   = 1'b0;
        in_rs2_en   = 1'b0;
        in_rs1_addr = '0;
        in_rs2_addr = '0;
        in_rd_en    = 1'b0;
        in_rd_addr  = '0;
        rf_rs1_data = '0;
        rf_rs2_data = '0;
        wb_valid    = '0;
        wb_addr     = '0;
        wb_data     = '0;
        flush       = 1'b0;
    endtask

    task automatic set_instr(input logic rd_en, input logic [AW-1:0] rd,
                             input logic rs1_en, input logic [AW-1:0] rs1, input logic [31:0] d1,
                             input logic rs2_en, input logic [AW-1:0] rs2, input logic [31:0] d2);
        in_valid    = 1'b1;
        in_rd_en    = rd_en;
        in_rd_addr  = rd;
        in_rs1_en   = rs1_en;
        in_rs1_addr = rs1;
        rf_rs1_data = d1;
        in_rs2_en   = rs2_en;
        in_rs2_addr = rs2;
        rf_rs2_data = d2;
    endtask

    task automatic set_wb(input int p, input logic [AW-1:0] addr, input logic [31:0] data);
        wb_valid[p]             = 1'b1;
        wb_addr[p*AW +: AW]     = addr;
        wb_data[p*XLEN +: XLEN] = data;
    endtask

    initial begin
        clear_in();
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_pend_err", pend_err, 0);
        check("rst_out_rs1", out_rs1_data, 0);
        check("rst_out_rd_addr", out_rd_addr, 0);
        for (int r = 0; r < 11; r++) check($sformatf("rst_pend%0d", r), dut.pend[r], 0);
        settle();
        check("rst_in_ready", in_ready, 1);

        // Independent stream: rd=1..4, sources r8 from the RF, one per cycle
        for (int i = 1; i <= 4; i++) begin
            set_instr(1, AW'(i), 1, 4'd8, 32'h11 * i, 0, 4'd0, 0);
            settle();
            check($sformatf("stream_ready%0d", i), in_ready, 1);
            tick();
            check($sformatf("stream_valid%0d", i), out_valid, 1);
            check($sformatf("stream_rs1_%0d", i), out_rs1_data, 32'h11 * i);
            check($sformatf("stream_rd%0d", i), out_rd_addr, i);
            if (i > 1) check($sformatf("stream_pend%0d", i - 1), dut.pend[i-1], 1);
        end
        clear_in();
        tick();
        check("stream_drain_valid", out_valid, 0);
        check("stream_pend4", dut.pend[4], 1);
        set_wb(0, 4'd1, 0);
        set_wb(1, 4'd2, 0);
        tick();
        check("stream_ret_pend1", dut.pend[1], 0);
        check("stream_ret_pend2", dut.pend[2], 0);
        check("stream_keep_pend3", dut.pend[3], 1);

        // RAW on r3: stall until port 1 writes it back, then forward
        clear_in();
        set_instr(1, 4'd6, 1, 4'd3, 32'h0, 0, 4'd0, 0);
        settle();
        check("raw_stall", in_ready, 0);
        tick();
        check("raw_no_issue", out_valid, 0);
        check("raw_still_stall", in_ready, 0);
        set_wb(1, 4'd3, 32'hDEADBEEF);
        settle();
        check("raw_wb_ready", in_ready, 1);
        tick();
        check("raw_valid", out_valid, 1);
        check("raw_fwd_data", out_rs1_data, 32'hDEADBEEF);
        check("raw_pend3", dut.pend[3], 0);
        clear_in();
        tick();
        check("raw_pend6", dut.pend[6], 1);
        set_wb(0, 4'd4, 0);
        set_wb(1, 4'd6, 0);
        tick();
        check("raw_ret_pend4", dut.pend[4], 0);
        check("raw_ret_pend6", dut.pend[6], 0);

        // WAW limit on r5
        clear_in();
        for (int k = 0; k < 3; k++) begin
            set_instr(1, 4'd5, 0, 4'd0, 0, 0, 4'd0, 0);
            settle();
            check($sformatf("waw_ready%0d", k), in_ready, 1);
            tick();
            check($sformatf("waw_pend%0d", k), dut.pend[5], k);
        end
        settle();
        check("waw_limit_stall", in_ready, 0);
        tick();
        check("waw_pend_full", dut.pend[5], 3);
        check("waw_drained", out_valid, 0);
        set_wb(0, 4'd5, 0);
        settle();
        check("waw_wb_no_credit", in_ready, 0);
        tick();
        check("waw_pend_after_wb", dut.pend[5], 2);
        wb_valid = '0;
        settle();
        check("waw_ready_after_wb", in_ready, 1);
        tick();
        check("waw_fourth_valid", out_valid, 1);
        clear_in();
        tick();
        check("waw_pend_end", dut.pend[5], 3);
        set_wb(0, 4'd5, 0);
        set_wb(1, 4'd5, 0);
        tick();
        check("waw_dual_wb", dut.pend[5], 1);
        clear_in();
        set_wb(0, 4'd5, 0);
        tick();
        check("waw_clean", dut.pend[5], 0);

        // Simultaneous increment and decrement on r2
        clear_in();
        set_instr(1, 4'd2, 0, 4'd0, 0, 0, 4'd0, 0);
        tick();
        tick();
        check("sim_pend_one", dut.pend[2], 1);
        clear_in();
        set_wb(0, 4'd2, 0);
        tick();
        check("sim_net_zero", dut.pend[2], 1);
        clear_in();
        set_instr(1, 4'd2, 0, 4'd0, 0, 0, 4'd0, 0);
        tick();
        clear_in();
        tick();
        check("sim_pend_two", dut.pend[2], 2);
        set_wb(0, 4'd2, 0);
        set_wb(1, 4'd2, 0);
        tick();
        check("sim_dual_dec", dut.pend[2], 0);
        check("sim_no_err", pend_err, 0);

        // Flush a held instruction writing r4
        clear_in();
        out_ready = 1'b0;
        set_instr(1, 4'd4, 0, 4'd0, 0, 0, 4'd0, 0);
        tick();
        clear_in();
        tick();
        check("flush_held", out_valid, 1);
        check("flush_held_rd", out_rd_addr, 4);
        flush = 1'b1;
        settle();
        check("flush_blocks", in_ready, 0);
        tick();
        check("flush_valid_low", out_valid, 0);
        check("flush_pend4", dut.pend[4], 0);
        flush = 1'b0;
        out_ready = 1'b1;
        set_instr(0, 4'd0, 1, 4'd4, 32'h44, 0, 4'd0, 0);
        settle();
        check("flush_reader_ready", in_ready, 1);
        tick();
        check("flush_reader_valid", out_valid, 1);
        check("flush_reader_data", out_rs1_data, 32'h44);
        clear_in();
        tick();

        // Underflow, out-of-range writeback, reset during a stall
        set_wb(0, 4'd12, 0);
        tick();
        check("oor_wb_no_err", pend_err, 0);
        clear_in();
        set_wb(0, 4'd7, 0);
        tick();
        check("uf_err", pend_err, 1);
        check("uf_pend7", dut.pend[7], 0);
        clear_in();
        tick();
        check("uf_sticky", pend_err, 1);
        set_instr(1, 4'd9, 0, 4'd0, 0, 0, 4'd0, 0);
        tick();
        clear_in();
        tick();
        check("rst_setup_pend9", dut.pend[9], 1);
        set_instr(0, 4'd0, 0, 4'd0, 0, 1, 4'd9, 32'h99);
        settle();
        check("rst_setup_stall", in_ready, 0);
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_pend9", dut.pend[9], 0);
        check("rst2_out_valid", out_valid, 0);
        check("rst2_pend_err", pend_err, 0);
        set_instr(0, 4'd0, 0, 4'd0, 0, 1, 4'd9, 32'h99);
        settle();
        check("rst2_ready", in_ready, 1);
        tick();
        check("rst2_rs2_data", out_rs2_data, 32'h99);
        clear_in();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
